// File: rtl/psum_requant.sv
// Partial-sum accumulator and requantizer for the adder-tree result stream.
// Groups cfg_tiles tree sums, then applies bias, rounding shift, ReLU and saturation into a small output FIFO.
module psum_requant #(
  parameter int ACC_W      = 20,
  parameter int PSUM_W     = 28,
  parameter int OUT_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             vld_i,
  input  logic [ACC_W-1:0] acc_i,
  input  logic [7:0]       cfg_tiles,
  input  logic [15:0]      cfg_bias,
  input  logic [4:0]       cfg_shift,
  input  logic             cfg_relu,
  output logic             out_vld_o,
  output logic [OUT_W-1:0] out_data_o,
  input  logic             out_rdy_i,
  output logic             busy_o,
  output logic             err_ovf_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic signed [PSUM_W:0] SAT_MAX = (PSUM_W+1)'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [PSUM_W:0] SAT_MIN = -SAT_MAX - (PSUM_W+1)'(1);

  typedef enum logic {IDLE, ACC} state_t;

  state_t                   state_reg;
  logic signed [PSUM_W-1:0] psum_reg;
  logic [7:0]               cnt_reg;
  logic [7:0]               tiles_reg;
  logic [15:0]              bias_reg;
  logic [4:0]               shift_reg;
  logic                     relu_reg;

  logic signed [PSUM_W-1:0] acc_ext;
  logic [7:0]               cnt_inc;
  assign acc_ext = {{(PSUM_W-ACC_W){acc_i[ACC_W-1]}}, acc_i};
  assign cnt_inc = cnt_reg + 8'd1;

  // Issue path: the group's configuration travels with its sum so a following
  // group may latch new settings while this one is still in the pipeline.
  logic                     issue_vld;
  logic signed [PSUM_W-1:0] issue_psum;
  logic [15:0]              issue_bias;
  logic [4:0]               issue_shift;
  logic                     issue_relu;

  always_comb begin
    issue_vld   = 1'b0;
    issue_psum  = acc_ext;
    issue_bias  = cfg_bias;
    issue_shift = cfg_shift;
    issue_relu  = cfg_relu;
    if (vld_i) begin
      if (state_reg == IDLE) begin
        issue_vld = (cfg_tiles <= 8'd1);
      end else begin
        issue_vld   = (cnt_inc == tiles_reg);
        issue_psum  = psum_reg + acc_ext;
        issue_bias  = bias_reg;
        issue_shift = shift_reg;
        issue_relu  = relu_reg;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
      psum_reg  <= '0;
      cnt_reg   <= '0;
      tiles_reg <= '0;
      bias_reg  <= '0;
      shift_reg <= '0;
      relu_reg  <= 1'b0;
    end else if (vld_i) begin
      if (state_reg == IDLE) begin
        tiles_reg <= cfg_tiles;
        bias_reg  <= cfg_bias;
        shift_reg <= cfg_shift;
        relu_reg  <= cfg_relu;
        psum_reg  <= acc_ext;
        cnt_reg   <= 8'd1;
        state_reg <= (cfg_tiles <= 8'd1) ? IDLE : ACC;
      end else if (issue_vld) begin
        state_reg <= IDLE;
      end else begin
        psum_reg <= psum_reg + acc_ext;
        cnt_reg  <= cnt_inc;
      end
    end
  end

  // Stage 1: bias add.
  logic                     s1_vld_reg;
  logic signed [PSUM_W-1:0] s1_sum_reg;
  logic [4:0]               s1_shift_reg;
  logic                     s1_relu_reg;
  logic signed [PSUM_W-1:0] bias_ext;
  assign bias_ext = {{(PSUM_W-16){issue_bias[15]}}, issue_bias};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_vld_reg   <= 1'b0;
      s1_sum_reg   <= '0;
      s1_shift_reg <= '0;
      s1_relu_reg  <= 1'b0;
    end else begin
      s1_vld_reg <= issue_vld;
      if (issue_vld) begin
        s1_sum_reg   <= issue_psum + bias_ext;
        s1_shift_reg <= issue_shift;
        s1_relu_reg  <= issue_relu;
      end
    end
  end

  // Stage 2: round-half-up shift, ReLU, saturate. One extra bit keeps the
  // rounding addend from overflowing at the top of the range.
  logic signed [PSUM_W:0] sum_w;
  logic signed [PSUM_W:0] rnd;
  logic signed [PSUM_W:0] r_shift;
  logic signed [PSUM_W:0] r_relu;
  logic [OUT_W-1:0]       s2_data_next;

  always_comb begin
    sum_w   = {s1_sum_reg[PSUM_W-1], s1_sum_reg};
    rnd     = '0;
    if (s1_shift_reg != 5'd0) rnd = (PSUM_W+1)'(1) << (s1_shift_reg - 5'd1);
    r_shift = (sum_w + rnd) >>> s1_shift_reg;
    r_relu  = (s1_relu_reg && r_shift[PSUM_W]) ? '0 : r_shift;
    if (r_relu > SAT_MAX)      s2_data_next = SAT_MAX[OUT_W-1:0];
    else if (r_relu < SAT_MIN) s2_data_next = SAT_MIN[OUT_W-1:0];
    else                       s2_data_next = r_relu[OUT_W-1:0];
  end

  logic             s2_vld_reg;
  logic [OUT_W-1:0] s2_data_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_vld_reg  <= 1'b0;
      s2_data_reg <= '0;
    end else begin
      s2_vld_reg <= s1_vld_reg;
      if (s1_vld_reg) s2_data_reg <= s2_data_next;
    end
  end

  // Output FIFO with a registered head so the last value is held when empty.
  logic [OUT_W-1:0] mem_reg [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg, rd_next;
  logic [PTR_W:0]   count_reg, remain;
  logic [OUT_W-1:0] data_reg;
  logic             err_reg;
  logic             pop, full, push_ok;

  assign pop     = (count_reg != '0) && out_rdy_i;
  assign full    = (count_reg == (PTR_W+1)'(FIFO_DEPTH));
  assign push_ok = s2_vld_reg && (!full || pop);
  assign rd_next = rd_ptr_reg + PTR_W'(pop);
  assign remain  = count_reg - (PTR_W+1)'(pop);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_reg[i] <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      data_reg   <= '0;
      err_reg    <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_reg[wr_ptr_reg] <= s2_data_reg;
        wr_ptr_reg          <= wr_ptr_reg + PTR_W'(1);
      end
      rd_ptr_reg <= rd_next;
      count_reg  <= remain + (PTR_W+1)'(push_ok);
      if (push_ok && remain == '0)  data_reg <= s2_data_reg;
      else if (pop && remain != '0) data_reg <= mem_reg[rd_next];
      if (s2_vld_reg && full && !pop) err_reg <= 1'b1;
    end
  end

  assign out_vld_o  = (count_reg != '0);
  assign out_data_o = data_reg;
  assign err_ovf_o  = err_reg;
  assign busy_o     = (state_reg == ACC) || s1_vld_reg || s2_vld_reg;

endmodule
